qerv_mem_seq: RTL and testbench



---
 rtl/qerv_mem_seq.sv | 133 +++++++++++++
 tb/tb_qerv_mem_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/qerv_mem_seq.sv
// qerv_mem_seq: load/store sequencer for the W-bit serial buffer register.
// Store: INIT phase shifts rs2 into the addressed byte lanes, then one bus cycle.
// Load: bus cycle, o_load on ack, then RUN replays the word serially to rd,
// flagging real data bits versus sign/zero fill.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word requests are
// rejected with a one-cycle o_misalign pulse instead of running a bus cycle).
//
// state | meaning
// IDLE  | waiting for i_req
// INIT  | store data being shifted into bufreg, byte lanes gated
// BUS   | Wishbone cycle outstanding, waiting for ack
// RUN   | loaded data replayed serially to rd
module qerv_mem_seq #(
  parameter  int W  = 1,
  localparam int LB = $clog2(W),
  localparam int CW = 5 - LB
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_we,
  input  logic [1:0] i_size,
  input  logic       i_signed,
  input  logic [1:0] i_lsb,
  input  logic       i_q_msb,
  output logic       o_init,
  output logic       o_run,
  output logic       o_byte_valid,
  output logic       o_load,
  output logic       o_dat_valid,
  output logic       o_sign,
  output logic       o_wb_cyc,
  output logic       o_wb_we,
  output logic [3:0] o_wb_sel,
  input  logic       i_wb_ack,
  output logic       o_done,
  output logic       o_misalign
);

  typedef enum logic [1:0] {IDLE, INIT, BUS, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sign_r;

  logic       cnt_done;
  logic [4:0] bit_pos;
  logic [1:0] byte_idx;
  logic       is_word;
  logic       is_half;
  logic       misalign_req;
  logic       dat_valid;

  assign cnt_done = &cnt;
  assign bit_pos  = 5'(cnt) << LB;
  assign byte_idx = bit_pos[4:3];
  assign is_word  = i_size[1];
  assign is_half  = (i_size == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign misalign_req = (is_half & i_lsb[0]) | (is_word & (i_lsb != 2'b00));
`else
  assign misalign_req = 1'b0;
`endif

  // Bytes above the first one are real data only for half/word loads.
  assign dat_valid = (state == RUN) &
                     (is_word | (byte_idx == 2'd0) | (is_half & (byte_idx <= 2'd1)));

  // Sequencer state, serial bit counter and load sign capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && !misalign_req)
            state <= i_we ? INIT : BUS;
        end
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt_done)
            state <= BUS;
        end
        BUS: begin
          if (i_wb_ack) begin
            if (i_we) begin
              state <= IDLE;
            end else begin
              state  <= RUN;
              sign_r <= 1'b0;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (dat_valid && i_signed)
            sign_r <= i_q_msb;
          if (cnt_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode; ack-related pulses are suppressed while reset is asserted.
  always_comb begin
    o_init       = (state == INIT);
    o_run        = (state == RUN);
    o_wb_cyc     = (state == BUS);
    o_wb_we      = (state == BUS) & i_we;
    o_byte_valid = (state == INIT) &
                   (({1'b0, byte_idx} + {1'b0, i_lsb}) <= 3'd3);
    o_dat_valid  = dat_valid;
    o_sign       = sign_r;
    o_load       = !i_rst & (state == BUS) & i_wb_ack & !i_we;
    o_done       = !i_rst & (((state == BUS) & i_wb_ack & i_we) |
                             ((state == RUN) & cnt_done));
    o_misalign   = !i_rst & (state == IDLE) & i_req & misalign_req;
    o_wb_sel     = 4'b0000;
    if (state == BUS) begin
      case (i_size)
        2'b00:   o_wb_sel = 4'b0001 << i_lsb;
        2'b01:   o_wb_sel = i_lsb[1] ? 4'b1100 : 4'b0011;
        default: o_wb_sel = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_qerv_mem_seq.sv
// Randomized self-checking bench for qerv_mem_seq. Expected behaviour comes
// from a cycle-by-cycle transaction model derived from bit positions and
// access sizes; the bench plays the bufreg by driving i_q_msb from the word.
module tb_qerv_mem_seq;
  localparam int W = 4;
  localparam int N = 32 / W;

  logic       clk = 1'b0;
  logic       rst, req, we, sgn, q_msb, ack;
  logic [1:0] size, lsb;
  logic       init, run, byte_valid, load, dat_valid, sign, cyc, wb_we, done, misalign;
  logic [3:0] sel;

  int n_cmp = 0;
  int n_err = 0;

  qerv_mem_seq #(.W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size),
    .i_signed(sgn), .i_lsb(lsb), .i_q_msb(q_msb),
    .o_init(init), .o_run(run), .o_byte_valid(byte_valid), .o_load(load),
    .o_dat_valid(dat_valid), .o_sign(sign), .o_wb_cyc(cyc), .o_wb_we(wb_we),
    .o_wb_sel(sel), .i_wb_ack(ack), .o_done(done), .o_misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_sel(input logic [1:0] sz, input logic [1:0] ls);
    logic [3:0] one;
    one = 4'b0001;
    case (sz)
      2'd0:    return one << ls;
      2'd1:    return ls[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic bit is_misaligned(input logic [1:0] sz, input logic [1:0] ls);
    return ((sz == 2'd1) && ls[0]) || (sz[1] && (ls != 2'd0));
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_cyc"},  32'(cyc), 0);
    check({tag, "_init"}, 32'(init), 0);
    check({tag, "_run"},  32'(run), 0);
    check({tag, "_load"}, 32'(load), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_sel"},  32'(sel), 0);
    check({tag, "_bv"},   32'(byte_valid), 0);
    check({tag, "_dv"},   32'(dat_valid), 0);
  endtask

  // Idle cycle with a stray ack: must be ignored since no cycle is open.
  task automatic idle_cycle();
    @(negedge clk);
    rst = 1'b0; req = 1'b0; ack = 1'($urandom_range(0, 1)); #1;
    check_quiet("idle");
    check("idle_mis", 32'(misalign), 0);
  endtask

  task automatic run_op(input bit w, input logic [1:0] sz, input bit sg, input logic [1:0] ls,
                        input logic [31:0] data, input int dly, input int rst_at);
    logic [31:0] sh;
    bit          trap;
    bit          dv;
    int          width;
    int          bpos;
    sh    = data >> (8 * ls);
    width = sz[1] ? 32 : (8 << sz);
    trap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = is_misaligned(sz, ls);
`endif
    @(negedge clk);
    rst = 1'b0; req = 1'b1; we = w; size = sz; sgn = sg; lsb = ls; ack = 1'b0; #1;
    check("req_cyc", 32'(cyc), 0);
    check("req_init", 32'(init), 0);
    check("req_mis", 32'(misalign), 32'(trap));
    if (trap) begin
      @(negedge clk);
      req = 1'b0; #1;
      check_quiet("trap_after");
      return;
    end
    if (w) begin
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        req = 1'($urandom_range(0, 1)); ack = 1'($urandom_range(0, 1)); #1;
        bpos = k * W;
        check("init_on", 32'(init), 1);
        check("init_bv", 32'(byte_valid), 32'(((bpos / 8) + ls) <= 3));
        check("init_cyc", 32'(cyc), 0);
        check("init_done", 32'(done), 0);
      end
    end
    for (int d = 0; d <= dly; d++) begin
      @(negedge clk);
      req = 1'($urandom_range(0, 1)); ack = (d == dly); #1;
      check("bus_cyc", 32'(cyc), 1);
      check("bus_we", 32'(wb_we), 32'(w));
      check("bus_sel", 32'(sel), 32'(exp_sel(sz, ls)));
      check("bus_load", 32'(load), 32'(!w && d == dly));
      check("bus_done", 32'(done), 32'(w && d == dly));
      check("bus_run", 32'(run), 0);
    end
    if (!w) begin
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        bpos  = k * W;
        req   = 1'($urandom_range(0, 1));
        ack   = 1'($urandom_range(0, 1));
        q_msb = sh[bpos + W - 1];
        rst   = (k == rst_at); #1;
        dv = sz[1] || (bpos < 8) || ((sz == 2'd1) && (bpos < 16));
        check("run_on", 32'(run), 1);
        check("run_cyc", 32'(cyc), 0);
        check("run_dv", 32'(dat_valid), 32'(dv));
        check("run_done", 32'(done), 32'(k == N - 1 && k != rst_at));
        if (!dv)
          check("run_sign", 32'(sign), 32'(sg ? sh[width - 1] : 1'b0));
        if (k == rst_at) break;
      end
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0; ack = 1'b0; #1;
    check_quiet("post");
    if (rst_at >= 0 && !w)
      check("post_rst_sign", 32'(sign), 0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; sgn = 1'b0; q_msb = 1'b0; ack = 1'b0;
    size = 2'd0; lsb = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req = 1'b1; #1;
    check_quiet("reset");
    check("reset_sign", 32'(sign), 0);
    check("reset_mis", 32'(misalign), 0);
    req = 1'b0;
    idle_cycle();

    run_op(1'b1, 2'd0, 1'b0, 2'd2, 32'h0, 0, -1);
    idle_cycle();
    run_op(1'b0, 2'd1, 1'b1, 2'd0, 32'h0000_8123, 0, -1);
    run_op(1'b0, 2'd2, 1'b0, 2'd0, 32'hDEAD_BEEF, 5, -1);
    run_op(1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_00FF, 1, -1);
    run_op(1'b0, 2'd2, 1'b1, 2'd1, 32'h1234_5678, 2, -1);
    run_op(1'b0, 2'd2, 1'b1, 2'd0, 32'hFFFF_FFFF, 1, 3);
    idle_cycle();

    for (int i = 0; i < 60; i++) begin
      bit          w;
      logic [1:0]  sz, ls;
      int          ra;
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ls = 2'($urandom_range(0, 3));
      ra = (!w && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, N - 2)) : -1;
      run_op(w, sz, 1'($urandom_range(0, 1)), ls, $urandom, int'($urandom_range(0, 4)), ra);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
